// File: rtl/adc_serial_responder.sv
// Transmitter side of the 3-wire serial ADC link: emulates a 12-bit ADCS7476-style
// converter (leading zeros, sample MSB first, then line release) for FPGA loopback.
module adc_serial_responder #(
  parameter int DATA_BITS   = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_clk,
  input  logic                 adc_cs,
  output logic                 adc_sd,
  output logic                 adc_sd_oe,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic                 pattern_sel,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 aborted
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] s);
    return {{LEAD_ZEROS{1'b0}}, s};
  endfunction

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   hold_reg;
  logic [DATA_BITS-1:0]   ramp;
  logic [FRAME_BITS-1:0]  shreg;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   clk_prev;
  logic                   cs_prev;

  // Synchronizers idle high so that a chip select held low through reset
  // release is seen as a falling edge and starts a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      cs_sync  <= '1;
      clk_prev <= 1'b1;
      cs_prev  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], adc_clk};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      cs_prev  <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic                  clk_fall;
  logic                  cs_fall;
  logic                  cs_rise;
  logic                  load_en;
  logic                  shift_en;
  logic [FRAME_BITS-1:0] frame_src;

  assign clk_fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise   = ~cs_prev & cs_sync[SYNC_STAGES-1];
  assign frame_src = build_frame(pattern_sel ? ramp : hold_reg);
  assign load_en   = (state == IDLE) && cs_fall;
  assign shift_en  = (state == SHIFT) && !cs_rise && clk_fall &&
                     (bit_cnt < CNT_W'(FRAME_BITS));

  // Shift register carries data only; its contents are don't-care outside SHIFT.
  always_ff @(posedge clk) begin
    if (load_en) begin
      shreg <= frame_src;
    end else if (shift_en) begin
      shreg <= shreg << 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      hold_reg   <= '0;
      ramp       <= '0;
      adc_sd     <= 1'b0;
      adc_sd_oe  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      if (sample_valid) begin
        hold_reg <= sample_in;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            adc_sd    <= frame_src[FRAME_BITS-1];
            adc_sd_oe <= 1'b1;
            busy      <= 1'b1;
            bit_cnt   <= CNT_W'(1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // A chip-select rise outranks a clock fall seen in the same cycle.
          if (cs_rise) begin
            adc_sd    <= 1'b0;
            adc_sd_oe <= 1'b0;
            busy      <= 1'b0;
            aborted   <= 1'b1;
            state     <= IDLE;
          end else if (clk_fall) begin
            if (bit_cnt < CNT_W'(FRAME_BITS)) begin
              adc_sd  <= shreg[FRAME_BITS-2];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              adc_sd     <= 1'b0;
              adc_sd_oe  <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              if (pattern_sel) begin
                ramp <= ramp + 1'b1;
              end
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench: a bus-master model drives adc_cs/adc_clk at clk/16 and
// reassembles the serial words; a 4-bit-sample instance exercises ramp wrap.
module tb_adc_serial_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_clk;
  logic        adc_cs;
  logic        sample_valid;
  logic        pattern_sel;
  logic [11:0] sample_in;
  logic        adc_sd, adc_sd_oe, busy, frame_done, aborted;
  logic        sd_s, oe_s, busy_s, fd_s, ab_s;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  int          ab_cnt = 0;
  int          oe_bad = 0;
  longint      fd_time = 0;
  longint      ab_time = 0;
  longint      fall_time = 0;
  longint      rise_cs_time = 0;
  logic [15:0] word, word_s;

  always #5 clk = ~clk;

  adc_serial_responder dut (
    .clk(clk), .reset(reset), .adc_clk(adc_clk), .adc_cs(adc_cs),
    .adc_sd(adc_sd), .adc_sd_oe(adc_sd_oe), .sample_in(sample_in),
    .sample_valid(sample_valid), .pattern_sel(pattern_sel), .busy(busy),
    .frame_done(frame_done), .aborted(aborted)
  );

  adc_serial_responder #(.DATA_BITS(4), .LEAD_ZEROS(12), .SYNC_STAGES(2)) u_small (
    .clk(clk), .reset(reset), .adc_clk(adc_clk), .adc_cs(adc_cs),
    .adc_sd(sd_s), .adc_sd_oe(oe_s), .sample_in(4'h0),
    .sample_valid(1'b0), .pattern_sel(1'b1), .busy(busy_s),
    .frame_done(fd_s), .aborted(ab_s)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_time = $time;
    end
    if (aborted === 1'b1) begin
      ab_cnt++;
      ab_time = $time;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_frame(input bit same_cycle);
    word = '0; word_s = '0; oe_bad = 0; fd_cnt = 0; ab_cnt = 0;
    adc_cs = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (same_cycle && c == 1) begin
        sample_in = 12'h123;
        sample_valid = 1'b1;
      end
      if (c == 2) sample_valid = 1'b0;
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      if (i < 16) begin
        word   = {word[14:0], adc_sd};
        word_s = {word_s[14:0], sd_s};
        if (adc_sd_oe !== 1'b1) oe_bad++;
      end else if (adc_sd_oe !== 1'b0 || busy !== 1'b0) begin
        oe_bad++;
      end
      adc_clk = 1'b1;
      repeat (8) tick();
      adc_clk = 1'b0;
      fall_time = $time;
      repeat (8) tick();
    end
  endtask

  task automatic end_frame();
    adc_cs = 1'b1;
    rise_cs_time = $time;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; adc_clk = 1'b0; adc_cs = 1'b1; sample_valid = 1'b0;
    sample_in = '0; pattern_sel = 1'b0;
    repeat (3) tick();
    checks++; if (adc_sd_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", adc_sd_oe); end
    checks++; if (adc_sd !== 1'b0) begin errors++; $display("FAIL reset_sd got %b want 0", adc_sd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b want 0", aborted); end
    reset = 1'b0;
    repeat (6) tick();
    checks++; if (adc_sd_oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got oe=%b busy=%b want 0 0", adc_sd_oe, busy);
    end
  endtask

  task automatic test_bit_order();
    pattern_sel = 1'b0;
    sample_in = 12'hA5C; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0; sample_in = '0;
    start_frame(1'b0);
    checks++; if (busy !== 1'b1 || adc_sd_oe !== 1'b1) begin
      errors++; $display("FAIL start_drive got busy=%b oe=%b want 1 1", busy, adc_sd_oe);
    end
    pulses(16);
    checks++; if (word !== 16'h0A5C) begin errors++; $display("FAIL bit_order got %h want 0a5c", word); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL done_count got %0d want 1", fd_cnt); end
    checks++; if (fd_time - fall_time != 30) begin
      errors++; $display("FAIL done_latency got %0d want 30", fd_time - fall_time);
    end
    checks++; if (oe_bad != 0) begin errors++; $display("FAIL oe_during_frame got %0d bad want 0", oe_bad); end
    checks++; if (adc_sd_oe !== 1'b0 || busy !== 1'b0 || adc_sd !== 1'b0) begin
      errors++; $display("FAIL release got oe=%b busy=%b sd=%b want 0 0 0", adc_sd_oe, busy, adc_sd);
    end
    end_frame();
  endtask

  task automatic test_ramp();
    pattern_sel = 1'b1;
    for (int f = 0; f < 3; f++) begin
      start_frame(1'b0);
      pulses(16);
      end_frame();
      checks++; if (word !== 16'(f)) begin errors++; $display("FAIL ramp_%0d got %h want %h", f, word, 16'(f)); end
    end
  endtask

  task automatic test_abort();
    start_frame(1'b0);
    pulses(7);
    checks++; if (adc_sd_oe !== 1'b1) begin errors++; $display("FAIL abort_pre_oe got %b want 1", adc_sd_oe); end
    adc_cs = 1'b1;
    rise_cs_time = $time;
    repeat (3) tick();
    checks++; if (adc_sd_oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_release got oe=%b busy=%b want 0 0", adc_sd_oe, busy);
    end
    repeat (5) tick();
    checks++; if (ab_cnt != 1) begin errors++; $display("FAIL abort_count got %0d want 1", ab_cnt); end
    checks++; if (ab_time - rise_cs_time != 30) begin
      errors++; $display("FAIL abort_latency got %0d want 30", ab_time - rise_cs_time);
    end
    checks++; if (fd_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", fd_cnt); end
    start_frame(1'b0);
    pulses(16);
    end_frame();
    checks++; if (word !== 16'h0003) begin errors++; $display("FAIL abort_ramp_kept got %h want 0003", word); end
  endtask

  task automatic test_idle_done_immunity();
    int idle_bad = 0;
    fd_cnt = 0;
    adc_cs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      adc_clk = 1'b1;
      repeat (5) begin tick(); if (adc_sd_oe !== 1'b0 || busy !== 1'b0) idle_bad++; end
      adc_clk = 1'b0;
      repeat (5) begin tick(); if (adc_sd_oe !== 1'b0 || busy !== 1'b0) idle_bad++; end
    end
    checks++; if (idle_bad != 0 || fd_cnt != 0) begin
      errors++; $display("FAIL idle_immunity got %0d active cycles %0d done want 0 0", idle_bad, fd_cnt);
    end
    start_frame(1'b0);
    pulses(20);
    checks++; if (word !== 16'h0004) begin errors++; $display("FAIL done_frame_word got %h want 0004", word); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL done_single_pulse got %0d want 1", fd_cnt); end
    checks++; if (oe_bad != 0) begin errors++; $display("FAIL done_immunity got %0d bad want 0", oe_bad); end
    end_frame();
  endtask

  task automatic test_same_cycle();
    pattern_sel = 1'b0;
    sample_in = 12'h0FF; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    start_frame(1'b1);
    pulses(16);
    end_frame();
    checks++; if (word !== 16'h00FF) begin errors++; $display("FAIL same_cycle_old got %h want 00ff", word); end
    start_frame(1'b0);
    pulses(16);
    end_frame();
    checks++; if (word !== 16'h0123) begin errors++; $display("FAIL same_cycle_new got %h want 0123", word); end
  endtask

  task automatic test_reset_mid();
    pattern_sel = 1'b1;
    start_frame(1'b0);
    pulses(9);
    checks++; if (adc_sd_oe !== 1'b1) begin errors++; $display("FAIL mid_pre_oe got %b want 1", adc_sd_oe); end
    #2 reset = 1'b1;
    #1;
    checks++; if (adc_sd_oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got oe=%b busy=%b want 0 0", adc_sd_oe, busy);
    end
    tick(); tick();
    reset = 1'b0;
    word = '0; word_s = '0; oe_bad = 0; fd_cnt = 0;
    repeat (4) tick();
    checks++; if (busy !== 1'b1 || adc_sd_oe !== 1'b1) begin
      errors++; $display("FAIL restart_after_reset got busy=%b oe=%b want 1 1", busy, adc_sd_oe);
    end
    pulses(16);
    end_frame();
    checks++; if (word !== 16'h0000 || fd_cnt != 1) begin
      errors++; $display("FAIL restart_frame got %h done=%0d want 0000 1", word, fd_cnt);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    pattern_sel = 1'b1;
    for (int f = 0; f < 17; f++) begin
      start_frame(1'b0);
      pulses(16);
      end_frame();
      checks++; if (word_s !== 16'(f % 16)) begin
        errors++; $display("FAIL wrap_small_%0d got %h want %h", f, word_s, 16'(f % 16));
      end
      if (f >= 15) begin
        checks++; if (word !== 16'(f)) begin errors++; $display("FAIL wrap_big_%0d got %h want %h", f, word, 16'(f)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_ramp();
    test_abort();
    test_idle_done_immunity();
    test_same_cycle();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Synthesizable transmitter end of the 3-wire serial ADC link (adc_clk, adc_cs, adc_sd) used by the badge ADC receiver.
- Emulates a 12-bit ADCS7476-style converter: leading zeros, then the sample MSB first, then release of the data line.
- Used for on-FPGA loopback of the ADC/waterfall path without the real converter.
- Sample source is either an external word or an internal ramp.
- Runs on the system/pixel clock and oversamples the master's adc_clk and adc_cs.

Parameters:
- DATA_BITS, 12: sample width.
- LEAD_ZEROS, 4: zero bits sent before the MSB. FRAME_BITS = LEAD_ZEROS + DATA_BITS = 16.
- SYNC_STAGES, 2: synchronizer depth on adc_clk and adc_cs (minimum 2).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- adc_clk, input, 1: serial clock from the master. The master samples adc_sd on its rising edge.
- adc_cs, input, 1: active-low chip select from the master.
- adc_sd, output, 1: serial data. Forced to 0 when adc_sd_oe = 0.
- adc_sd_oe, output, 1: data-line drive enable. 0 means high-Z on the pad.
- sample_in, input, DATA_BITS: external sample word.
- sample_valid, input, 1: loads sample_in into the holding register.
- pattern_sel, input, 1: 0 selects the holding register, 1 selects the ramp counter.
- busy, output, 1: high while a frame is being shifted.
- frame_done, output, 1: one-cycle pulse when a frame completes.
- aborted, output, 1: one-cycle pulse when adc_cs rises before the frame completes.

Behaviour:
- Reset values:
  - adc_sd = 0, adc_sd_oe = 0, busy = 0, frame_done = 0, aborted = 0.
  - Holding register = 0, ramp = 0, bit counter = 0, state = IDLE.
  - adc_cs synchronizer flops reset to 1; adc_clk synchronizer flops reset to 1.
- Synchronizer and edge detection:
  - adc_clk and adc_cs each pass through SYNC_STAGES flops, plus one more flop for edge detection.
  - An edge seen on the external pin affects the outputs exactly SYNC_STAGES+1 clk cycles later.
  - Each adc_clk phase (high and low) must last at least SYNC_STAGES+2 clk cycles.
- Holding register: loads sample_in on any cycle where sample_valid = 1, independent of state.
- State IDLE:
  - adc_sd_oe = 0, busy = 0.
  - On a synchronized adc_cs falling edge:
    - Snapshot the source into the shift register as {LEAD_ZEROS zeros, sample}.
    - The source is the ramp if pattern_sel = 1, otherwise the holding register value from before this cycle. A sample_valid on the same cycle applies to the next conversion.
    - Set adc_sd_oe = 1, adc_sd = bit 0 of the frame (a zero), busy = 1, bit counter = 1.
    - Go to SHIFT.
  - adc_clk edges while adc_cs is high are ignored.
- State SHIFT:
  - On each synchronized adc_clk falling edge with counter < FRAME_BITS: shift left, drive the next bit on adc_sd, and increment the counter.
  - Falling edge number k (1..15) drives frame bit k. Bit 4 is the sample MSB and bit 15 is the sample LSB.
  - On falling edge FRAME_BITS (the 16th):
    - adc_sd_oe = 0, adc_sd = 0, busy = 0.
    - Pulse frame_done for one cycle.
    - Increment the ramp by 1 if pattern_sel = 1, wrapping 2^DATA_BITS-1 to 0.
    - Go to DONE.
  - Synchronized adc_cs rising edge before completion:
    - adc_sd_oe = 0, adc_sd = 0, busy = 0.
    - Pulse aborted for one cycle. The ramp is unchanged.
    - Go to IDLE.
  - If an adc_cs rise and an adc_clk fall are seen in the same cycle, the adc_cs rise wins (abort).
- State DONE:
  - Outputs stay released.
  - Further adc_clk edges are ignored.
  - A synchronized adc_cs rise returns to IDLE with no pulse.
- adc_cs low at reset release is treated as a falling edge, so a frame starts normally.
- Asserting reset mid-frame immediately releases the line (adc_sd_oe = 0) and returns to IDLE.
- adc_sd changes only on adc_clk falling edges (or on the adc_cs fall). It is stable across every adc_clk rising edge.

Test Plan:
- Bit order: pattern_sel = 0, sample_valid pulse with sample_in = 12'hA5C. Master drops adc_cs, then gives 16 adc_clk pulses at clk/16. Required: adc_sd sampled on adc_clk rises reads 0000_1010_0101_1100. frame_done fires once, 3 clk after the 16th fall. adc_sd_oe = 0 afterwards.
- Ramp: pattern_sel = 1, three full frames. Required: received words are 0, 1, 2. After reset with ramp preset to 4095 by 4095 frames, the next frame reads 4095 and the following frame reads 0.
- Abort: raise adc_cs after 7 falling edges. Required: aborted pulses once, adc_sd_oe = 0 within 3 clk, ramp unchanged. The next frame delivers the same ramp value.
- Idle and DONE immunity: adc_clk toggling with adc_cs high leaves adc_sd_oe = 0, busy = 0. Extra adc_clk pulses after the 16th keep the line released with no second frame_done.
- Same-cycle sample update: sample_valid with 12'h123 on the same clk as the synchronized adc_cs fall while the holding register is 12'h0FF. Required: the frame carries 12'h0FF and the next frame carries 12'h123.
- Reset mid-frame: assert reset after 9 falling edges. Required: adc_sd_oe = 0, busy = 0 asynchronously. After release with adc_cs still low, a new frame starts.
